// File: rtl/cpc_ram_pkg.sv
// Shared types and the block-to-page mapping table for the CPC RAM bank controller.
package cpc_ram_pkg;

    typedef enum logic [2:0] {
        MODE_0, MODE_1, MODE_2, MODE_3, MODE_4, MODE_5, MODE_6, MODE_7
    } mode_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_LATCH,
        WR_HOLD
    } wr_state_t;

    typedef enum logic [1:0] {
        WT_IDLE,
        WT_WAIT,
        WT_DONE
    } wt_state_t;

    localparam logic [1:0] PORT_ID = 2'b11;

    // Returns {hit, page}; blk 1 remap of mode 3 is deliberately left internal.
    function automatic logic [2:0] map_page(input mode_t mode, input logic [1:0] blk);
        logic [2:0] res;
        res = 3'b000;
        case (mode)
            MODE_1, MODE_3: res = {blk == 2'd3, 2'd3};
            MODE_2:         res = {1'b1, blk};
            MODE_4, MODE_5, MODE_6, MODE_7:
                            res = {blk == 2'd1, mode[1:0]};
            default:        res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpc_ram_bank_ctrl_if.sv
// CPC expansion bus as seen by the RAM bank controller: Z80 side in, SRAM/CPC side out.
interface cpc_ram_bank_ctrl_if #(parameter int BANK_BITS = 3);

    logic                 BUSRESET_B;
    logic [15:0]          A;
    logic [7:0]           D_IN;
    logic [7:0]           D_OUT;
    logic                 D_OE;
    logic                 MREQ_B;
    logic                 IOREQ_B;
    logic                 RD_B;
    logic                 WR_B;
    logic                 M1_B;
    logic                 RAMRD_B;
    logic [BANK_BITS+1:0] HIADR;
    logic                 RAMCS_B;
    logic                 RAMOE_B;
    logic                 RAMWE_B;
    logic                 RAMDIS;
    logic                 READY_PD;

    modport master (
        output BUSRESET_B, A, D_IN, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RAMRD_B,
        input  D_OUT, D_OE, HIADR, RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS, READY_PD
    );

    modport slave (
        input  BUSRESET_B, A, D_IN, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RAMRD_B,
        output D_OUT, D_OE, HIADR, RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS, READY_PD
    );

endinterface

// File: rtl/cpc_ram_wait_gen.sv
// READY wait-state generator: holds READY low for WAIT_CYCLES clocks per mapped access.
//   state   | meaning
//   WT_IDLE | no mapped access seen yet in this MREQ cycle
//   WT_WAIT | pulling READY low, down-counter running
//   WT_DONE | wait served, waiting for MREQ_B to rise
module cpc_ram_wait_gen
    import cpc_ram_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic CLK,
    input  logic RESET_B,
    input  logic BUSRESET_B,
    input  logic MREQ_B,
    input  logic mapped,
    output logic ready_pd
);

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            logic unused_ok;
            assign unused_ok = ^{CLK, RESET_B, BUSRESET_B, MREQ_B, mapped};
            assign ready_pd  = 1'b0;
        end else begin : g_wait
            wt_state_t  state;
            wt_state_t  state_nxt;
            logic [2:0] cnt;
            logic [2:0] cnt_nxt;

            always_ff @(posedge CLK or negedge RESET_B) begin
                if (!RESET_B) begin
                    state <= WT_IDLE;
                    cnt   <= 3'd0;
                end else if (!BUSRESET_B) begin
                    state <= WT_IDLE;
                    cnt   <= 3'd0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                case (state)
                    WT_IDLE: begin
                        if (mapped) begin
                            state_nxt = WT_WAIT;
                            cnt_nxt   = 3'(WAIT_CYCLES - 1);
                        end
                    end
                    WT_WAIT: begin
                        // A vanished MREQ must never leave READY stuck low.
                        if (MREQ_B) begin
                            state_nxt = WT_IDLE;
                            cnt_nxt   = 3'd0;
                        end else if (cnt == 3'd0) begin
                            state_nxt = WT_DONE;
                        end else begin
                            cnt_nxt = cnt - 3'd1;
                        end
                    end
                    WT_DONE: begin
                        if (MREQ_B) begin
                            state_nxt = WT_IDLE;
                        end
                    end
                    default: begin
                        state_nxt = WT_IDLE;
                        cnt_nxt   = 3'd0;
                    end
                endcase
            end

            assign ready_pd = (state == WT_WAIT);
        end
    endgenerate

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC RAM expansion controller: captures &7Fxx RAM config writes, maps Z80 memory cycles to SRAM.
// Optional config readback on IN &7Fxx is enabled by defining CPC_RAM_READBACK_EN.
//   state    | meaning
//   WR_IDLE  | waiting for a config port write
//   WR_LATCH | config captured into the pending registers
//   WR_HOLD  | mapping updated, waiting for IOREQ_B to rise
module cpc_ram_bank_ctrl
    import cpc_ram_pkg::*;
#(
    parameter int BANK_BITS   = 3,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                CLK,
    input  logic                RESET_B,
    cpc_ram_bank_ctrl_if.slave  bus
);

    localparam int HW = BANK_BITS + 2;

    wr_state_t              wr_state;
    wr_state_t              wr_nxt;
    mode_t                  mode;
    mode_t                  pend_mode;
    logic [BANK_BITS-1:0]   bank;
    logic [BANK_BITS-1:0]   pend_bank;
    logic [BANK_BITS-1:0]   bank_new;
    logic                   iowr;
    logic                   hit;
    logic [1:0]             page;
    logic                   mapped;
    logic [HW-1:0]          hiadr_map;
    logic [HW-1:0]          hiadr_q;
    logic                   ready_pd;
    logic                   unused_ok;

    assign iowr = !bus.IOREQ_B && !bus.WR_B && !bus.A[15] && bus.M1_B
                  && (bus.D_IN[7:6] == PORT_ID);

    // Upper bank bits come inverted from A8 upwards, as on the 6128 expansion boards.
    always_comb begin
        bank_new      = '0;
        bank_new[2:0] = bus.D_IN[5:3];
        for (int i = 3; i < BANK_BITS; i++) begin
            bank_new[i] = ~bus.A[i + 5];
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            wr_state  <= WR_IDLE;
            mode      <= MODE_0;
            bank      <= '0;
            pend_mode <= MODE_0;
            pend_bank <= '0;
        end else if (!bus.BUSRESET_B) begin
            wr_state  <= WR_IDLE;
            mode      <= MODE_0;
            bank      <= '0;
            pend_mode <= MODE_0;
            pend_bank <= '0;
        end else begin
            wr_state <= wr_nxt;
            if (wr_state == WR_IDLE && iowr) begin
                pend_mode <= mode_t'(bus.D_IN[2:0]);
                pend_bank <= bank_new;
            end
            if (wr_state == WR_LATCH) begin
                mode <= pend_mode;
                bank <= pend_bank;
            end
        end
    end

    always_comb begin
        wr_nxt = wr_state;
        case (wr_state)
            WR_IDLE:  if (iowr) wr_nxt = WR_LATCH;
            WR_LATCH: wr_nxt = WR_HOLD;
            WR_HOLD:  if (bus.IOREQ_B) wr_nxt = WR_IDLE;
            default:  wr_nxt = WR_IDLE;
        endcase
    end

    assign {hit, page} = map_page(mode, bus.A[15:14]);
    // A port write seen alongside MREQ keeps the SRAM quiet.
    assign mapped      = !bus.MREQ_B && hit && !iowr;
    assign hiadr_map   = {bank, page};

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            hiadr_q <= '0;
        end else if (!bus.BUSRESET_B) begin
            hiadr_q <= '0;
        end else if (mapped) begin
            hiadr_q <= hiadr_map;
        end
    end

    assign bus.HIADR   = mapped ? hiadr_map : hiadr_q;
    assign bus.RAMCS_B = !mapped;
    assign bus.RAMOE_B = mapped ? (bus.RD_B | bus.RAMRD_B) : 1'b1;
    assign bus.RAMWE_B = mapped ? bus.WR_B : 1'b1;
    assign bus.RAMDIS  = mapped;

    cpc_ram_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_gen (
        .CLK        (CLK),
        .RESET_B    (RESET_B),
        .BUSRESET_B (bus.BUSRESET_B),
        .MREQ_B     (bus.MREQ_B),
        .mapped     (mapped),
        .ready_pd   (ready_pd)
    );

    assign bus.READY_PD = ready_pd;

`ifdef CPC_RAM_READBACK_EN
    logic       iord;
    logic       d_oe_q;
    logic [7:0] d_out_q;

    assign iord = !bus.IOREQ_B && !bus.RD_B && !bus.A[15] && bus.M1_B;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            d_oe_q  <= 1'b0;
            d_out_q <= 8'h00;
        end else if (!bus.BUSRESET_B) begin
            d_oe_q  <= 1'b0;
            d_out_q <= 8'h00;
        end else begin
            d_oe_q  <= iord;
            d_out_q <= iord ? {PORT_ID, bank[2:0], mode} : 8'h00;
        end
    end

    assign bus.D_OE  = d_oe_q;
    assign bus.D_OUT = d_out_q;
`else
    assign bus.D_OE  = 1'b0;
    assign bus.D_OUT = 8'h00;
`endif

    assign unused_ok = ^bus.A[13:0];

endmodule
